// File: rtl/frame_tx_pkg.sv
//------------------------------------------------------------------------------
// Module   : frame_tx_pkg
// Purpose  : Shared constants, FSM state encoding and parity helper for frame_tx.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package frame_tx_pkg;

    localparam int FRAME_W              = 9;
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic frame_parity(input logic [FRAME_W-1:0] f, input logic odd);
        return (^f) ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_tx_baud_tick.sv
//------------------------------------------------------------------------------
// Module   : baud_tick
// Purpose  : Free-running bit-period counter with a one-cycle terminal tick.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module baud_tick #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wrapping at terminal count means every new bit starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == c_last) && !i_clear;

endmodule

`default_nettype wire

// File: rtl/frame_tx.sv
//------------------------------------------------------------------------------
// Module   : frame_tx
// Purpose  : UART-style serialiser for 9-bit frames with send/send_ready handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_tx
    import frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = FRAME_W,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               send,
    output logic               send_ready,
    output logic               tx,
    output logic               tx_done
);

    localparam int               BIT_W        = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] c_last_bit   = BIT_W'(DATA_BITS - 1);
    localparam logic             c_last_stop  = (STOP_BITS > 1);
    localparam logic             c_parity_en  = (PARITY_EN != 0);
    localparam logic             c_parity_odd = (PARITY_ODD != 0);

    state_t             r_state,      w_state_next;
    logic [FRAME_W-1:0] r_shift,      w_shift_next;
    logic [BIT_W-1:0]   r_bit_idx,    w_bit_idx_next;
    logic               r_stop_cnt,   w_stop_cnt_next;
    logic               r_parity,     w_parity_next;
    logic               r_tx,         w_tx_next;
    logic               r_send_ready, w_send_ready_next;
    logic               r_tx_done,    w_tx_done_next;
    logic               w_tick;
    logic               w_baud_clear;

    assign w_baud_clear = (r_state == ST_IDLE);

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_baud_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_stop_cnt   <= 1'b0;
            r_parity     <= 1'b0;
            r_tx         <= 1'b1;
            r_send_ready <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_stop_cnt   <= w_stop_cnt_next;
            r_parity     <= w_parity_next;
            r_tx         <= w_tx_next;
            r_send_ready <= w_send_ready_next;
            r_tx_done    <= w_tx_done_next;
        end
    end

    // Outputs are registered, so tx is computed for the state being entered.
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_idx_next    = r_bit_idx;
        w_stop_cnt_next   = r_stop_cnt;
        w_parity_next     = r_parity;
        w_tx_next         = r_tx;
        w_send_ready_next = r_send_ready;
        w_tx_done_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next         = 1'b1;
                w_send_ready_next = 1'b1;
                if (r_send_ready && send) begin
                    w_state_next      = ST_START;
                    w_shift_next      = frame;
                    w_parity_next     = frame_parity(frame, c_parity_odd);
                    w_bit_idx_next    = '0;
                    w_stop_cnt_next   = 1'b0;
                    w_tx_next         = 1'b0;
                    w_send_ready_next = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_last_bit) begin
                        if (c_parity_en) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + BIT_W'(1);
                        w_shift_next   = {1'b0, r_shift[FRAME_W-1:1]};
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    if (r_stop_cnt == c_last_stop) begin
                        w_state_next      = ST_IDLE;
                        w_send_ready_next = 1'b1;
                        w_tx_done_next    = 1'b1;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    assign send_ready = r_send_ready;
    assign tx         = r_tx;
    assign tx_done    = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_frame_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_frame_tx
// Purpose  : Randomised self-checking bench for frame_tx (no parity, even, odd).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_tx;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [8:0] frame = 9'h000;
    logic       send  = 1'b0;
    logic [2:0] rdy;
    logic [2:0] txl;
    logic [2:0] done;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut_np (.clk(clk), .rst(rst), .frame(frame), .send(send),
              .send_ready(rdy[0]), .tx(txl[0]), .tx_done(done[0]));

    frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut_even (.clk(clk), .rst(rst), .frame(frame), .send(send),
                .send_ready(rdy[1]), .tx(txl[1]), .tx_done(done[1]));

    frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_dut_odd (.clk(clk), .rst(rst), .frame(frame), .send(send),
               .send_ready(rdy[2]), .tx(txl[2]), .tx_done(done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: line value is a pure function of the latched frame and
    // the number of cycles elapsed since acceptance.
    function automatic int has_parity(input int i);
        return (i != 0) ? 1 : 0;
    endfunction

    function automatic logic odd_parity(input int i);
        return (i == 2);
    endfunction

    function automatic logic line_bit(input logic [8:0] f, input int pos, input int i);
        int b;
        b = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 9) return f[b-1];
        if (b == 10 && has_parity(i) != 0) return (^f) ^ odd_parity(i);
        return 1'b1;
    endfunction

    logic       m_busy  [3] = '{1'b0, 1'b0, 1'b0};
    logic       m_ready [3] = '{1'b0, 1'b0, 1'b0};
    logic       m_tx    [3] = '{1'b1, 1'b1, 1'b1};
    logic       m_done  [3] = '{1'b0, 1'b0, 1'b0};
    logic [8:0] m_frame [3] = '{9'h0, 9'h0, 9'h0};
    int         m_pos   [3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i]  = 1'b0;
                m_ready[i] = 1'b0;
                m_tx[i]    = 1'b1;
                m_done[i]  = 1'b0;
                m_pos[i]   = 0;
            end else begin
                m_done[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (m_ready[i] && send) begin
                        m_busy[i]  = 1'b1;
                        m_ready[i] = 1'b0;
                        m_frame[i] = frame;
                        m_pos[i]   = 0;
                        m_tx[i]    = 1'b0;
                    end else begin
                        m_ready[i] = 1'b1;
                        m_tx[i]    = 1'b1;
                    end
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                    if (m_pos[i] == CPB * (11 + has_parity(i))) begin
                        m_busy[i]  = 1'b0;
                        m_ready[i] = 1'b1;
                        m_done[i]  = 1'b1;
                        m_tx[i]    = 1'b1;
                    end else begin
                        m_tx[i] = line_bit(m_frame[i], m_pos[i], i);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("tx[%0d]", i),         32'(txl[i]),  32'(m_tx[i]));
            chk($sformatf("send_ready[%0d]", i), 32'(rdy[i]),  32'(m_ready[i]));
            chk($sformatf("tx_done[%0d]", i),    32'(done[i]), 32'(m_done[i]));
        end
    end

    task automatic pulse(input logic [8:0] f);
        frame = f;
        send  = 1'b1;
        @(negedge clk);
        send  = 1'b0;
        frame = 9'($urandom);
    endtask

    task automatic wait_all_ready(input int budget);
        int n;
        n = 0;
        while (rdy !== 3'b111 && n < budget) begin
            @(negedge clk);
            frame = 9'($urandom);
            n++;
        end
        if (rdy !== 3'b111) chk("ready_timeout", 32'(rdy), 32'h7);
    endtask

    initial begin
        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("reset_tx",  32'(txl), 32'h7);
        chk("reset_rdy", 32'(rdy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_rdy",  32'(rdy),  32'h7);
        chk("release_done", 32'(done), 32'h0);

        // Basic frame, with parity variants running alongside
        pulse(9'h1A5);
        wait_all_ready(200);

        // Busy-ignore: second request mid-frame must be dropped
        pulse(9'h1A5);
        repeat (20) @(negedge clk);
        pulse(9'h0FF);
        wait_all_ready(200);
        repeat (3) @(negedge clk);

        // Back-to-back: request on the cycle after send_ready rises
        pulse(9'h001);
        begin
            int n;
            n = 0;
            while (rdy[0] !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready_rise", 32'(rdy[0]), 32'h1);
        end
        pulse(9'h100);
        wait_all_ready(200);

        // send held high across several frames
        frame = 9'($urandom);
        send  = 1'b1;
        repeat (120) begin
            @(negedge clk);
            frame = 9'($urandom);
        end
        send = 1'b0;
        wait_all_ready(200);

        // Random frames with random gaps and ignored mid-frame requests
        for (int k = 0; k < 8; k++) begin
            wait_all_ready(200);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse(9'($urandom));
            repeat ($urandom_range(5, 30)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) pulse(9'($urandom));
        end
        wait_all_ready(200);

        // Mid-frame asynchronous reset during data bit 3
        pulse(9'h1A5);
        repeat (17) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_tx",  32'(txl), 32'h7);
        chk("async_rdy", 32'(rdy), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rerelease_rdy", 32'(rdy), 32'h7);
        pulse(9'h055);
        wait_all_ready(200);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
